// File: rtl/cic_decimator_mc.sv
`default_nettype none
// ============================================================================
// Module      : cic_decimator_mc
// Description : Multi-channel CIC decimator with a runtime power-of-two rate,
//               valid/ready streaming on both sides and exact gain
//               normalisation (round-half-up, saturate).
//               CH lanes share one phase counter and one control path.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   rate_log2  : decimation exponent (0 -> 1, >RL_MAX -> RL_MAX)
//   in_valid   : input beat valid
//   in_ready   : input beat accepted when in_valid && in_ready
//   in_data    : CH x W signed samples, channel c at [c*W +: W]
//   out_valid  : decimated beat valid
//   out_ready  : downstream accepts
//   out_data   : CH x OW signed samples, channel c at [c*OW +: OW]
//   rate_busy  : high during the single rate-change flush cycle
//
// Revision    : 1.0  initial release
// ============================================================================
module cic_decimator_mc #(
    parameter int W      = 16,
    parameter int OW     = 16,
    parameter int CH     = 4,
    parameter int N      = 3,
    parameter int M      = 1,
    parameter int RL_MAX = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(RL_MAX+1)-1:0] rate_log2,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CH*W-1:0]            in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CH*OW-1:0]           out_data,
    output logic                       rate_busy
);

    localparam int c_rlw = $clog2(RL_MAX + 1);
    // Datapath width large enough that the wrapped result is exact at the
    // largest rate; smaller rates simply use fewer of the bits.
    localparam int c_dw  = W + N * (RL_MAX + M - 1);
    // Scaling width: room for the left shift (OW > W) plus rounding carry.
    localparam int c_ew  = c_dw + (OW - W) + 2;
    localparam int c_pw  = RL_MAX;
    localparam int c_pw1 = RL_MAX + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_dw-1:0]  r_integ [CH][N];
    logic [c_dw-1:0]  r_dly   [CH][N][M];
    logic [c_pw-1:0]  r_phase;
    logic             r_snap;
    logic [c_rlw-1:0] r_rl;
    logic             r_out_valid;
    logic [CH*OW-1:0] r_out_data;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic [c_rlw-1:0]  w_rate_sat;
    logic [c_pw1-1:0]  w_last;
    logic              w_bnd;
    logic              w_flush;
    logic              w_load;
    logic              w_accept;

    always_comb begin
        w_rate_sat = rate_log2;
        if (rate_log2 == '0)
            w_rate_sat = c_rlw'(1);
        else if (rate_log2 > c_rlw'(RL_MAX))
            w_rate_sat = c_rlw'(RL_MAX);
    end

    // Phase value of the last beat of a block: 2^rl - 1.
    assign w_last   = (c_pw1'(1) << r_rl) - c_pw1'(1);
    assign w_bnd    = ({1'b0, r_phase} == w_last);

    // A rate change never interrupts a pending snapshot.
    assign w_flush  = (w_rate_sat != r_rl) && !r_snap;
    assign w_load   = r_snap && (!r_out_valid || out_ready);
    assign in_ready = !w_flush && !(r_snap && r_out_valid && !out_ready);
    assign w_accept = in_valid && in_ready;

    assign rate_busy = w_flush;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // ------------------------------------------------------------------
    // Integrator cascade: each stage adds the freshly updated value of the
    // previous stage, so the last stage already includes the current beat.
    // ------------------------------------------------------------------
    logic [c_dw-1:0] w_integ_nx [CH][N];

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            w_integ_nx[c][0] = r_integ[c][0] +
                {{(c_dw-W){in_data[c*W+W-1]}}, in_data[c*W +: W]};
            for (int k = 1; k < N; k++)
                w_integ_nx[c][k] = r_integ[c][k] + w_integ_nx[c][k-1];
        end
    end

    // ------------------------------------------------------------------
    // Comb chain (combinational), fed by the frozen last integrator.
    // ------------------------------------------------------------------
    logic [c_dw-1:0] w_comb_in  [CH][N];
    logic [c_dw-1:0] w_comb_out [CH];

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            w_comb_in[c][0] = r_integ[c][N-1];
            for (int k = 1; k < N; k++)
                w_comb_in[c][k] = w_comb_in[c][k-1] - r_dly[c][k-1][M-1];
            w_comb_out[c] = w_comb_in[c][N-1] - r_dly[c][N-1][M-1];
        end
    end

    // ------------------------------------------------------------------
    // Gain normalisation: shift by N*(rl+M-1) - (OW-W).
    // The rounding constant (1<<rsh)>>1 is 2^(S-1) for S>0 and 0 otherwise,
    // so one expression covers both shift directions.
    // ------------------------------------------------------------------
    logic signed [15:0]      w_shamt;
    logic [7:0]              w_rsh;
    logic [7:0]              w_lsh;
    logic signed [c_ew-1:0]  w_ext [CH];
    logic signed [c_ew-1:0]  w_rnd [CH];
    logic signed [c_ew-1:0]  w_sh  [CH];
    logic [CH*OW-1:0]        w_scaled;

    assign w_shamt = 16'(N * (int'(r_rl) + M - 1) - (OW - W));
    assign w_rsh   = (w_shamt > 0) ? w_shamt[7:0] : 8'd0;
    assign w_lsh   = (w_shamt < 0) ? 8'(-w_shamt) : 8'd0;

    always_comb begin
        w_scaled = '0;
        for (int c = 0; c < CH; c++) begin
            w_ext[c] = {{(c_ew-c_dw){w_comb_out[c][c_dw-1]}}, w_comb_out[c]};
            w_rnd[c] = w_ext[c] + ((c_ew'(1) << w_rsh) >> 1);
            w_sh[c]  = (w_rnd[c] >>> w_rsh) <<< w_lsh;
            if (!w_sh[c][c_ew-1] && (|w_sh[c][c_ew-2:OW-1]))
                w_scaled[c*OW +: OW] = {1'b0, {(OW-1){1'b1}}};
            else if (w_sh[c][c_ew-1] && !(&w_sh[c][c_ew-2:OW-1]))
                w_scaled[c*OW +: OW] = {1'b1, {(OW-1){1'b0}}};
            else
                w_scaled[c*OW +: OW] = w_sh[c][OW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < N; k++) begin
                    r_integ[c][k] <= '0;
                    for (int j = 0; j < M; j++)
                        r_dly[c][k][j] <= '0;
                end
            end
            r_phase     <= '0;
            r_snap      <= 1'b0;
            r_rl        <= w_rate_sat;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_flush) begin
                for (int c = 0; c < CH; c++) begin
                    for (int k = 0; k < N; k++) begin
                        r_integ[c][k] <= '0;
                        for (int j = 0; j < M; j++)
                            r_dly[c][k][j] <= '0;
                    end
                end
                r_phase <= '0;
                r_rl    <= w_rate_sat;
            end else begin
                if (w_accept) begin
                    for (int c = 0; c < CH; c++)
                        for (int k = 0; k < N; k++)
                            r_integ[c][k] <= w_integ_nx[c][k];
                    r_phase <= w_bnd ? '0 : r_phase + c_pw'(1);
                end
                // Comb delay lines advance only when a snapshot is taken.
                if (w_load) begin
                    for (int c = 0; c < CH; c++) begin
                        for (int k = 0; k < N; k++) begin
                            r_dly[c][k][0] <= w_comb_in[c][k];
                            for (int j = 1; j < M; j++)
                                r_dly[c][k][j] <= r_dly[c][k][j-1];
                        end
                    end
                end
                r_snap <= (r_snap && !w_load) || (w_accept && w_bnd);
            end

            // Flush cycles never load (snap is 0), so draining still works.
            if (w_load) begin
                r_out_data  <= w_scaled;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cic_decimator_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_cic_decimator_mc
// Description : Self-checking bench for cic_decimator_mc. The reference
//               computes each decimated sample as a direct FIR convolution of
//               the accepted-sample history with the CIC impulse response
//               (boxcar of length R*M convolved N times), then normalises.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cic_decimator_mc;

    localparam int W = 16, OW = 16, CH = 4, N = 3, M = 1, RL_MAX = 6, RLW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [RLW-1:0]    rate_log2;
    logic              in_valid, in_ready;
    logic [CH*W-1:0]   in_data;
    logic              out_valid, out_ready;
    logic [CH*OW-1:0]  out_data;
    logic              rate_busy;

    cic_decimator_mc #(.W(W), .OW(OW), .CH(CH), .N(N), .M(M), .RL_MAX(RL_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .rate_log2(rate_log2),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rate_busy(rate_busy)
    );

    // Second instance: OW = 20, single channel, constant 3 at rate 2^1.
    logic [RLW-1:0] d_rate = 3'd1;
    logic           d_in_valid = 1'b1;
    logic           d_out_ready = 1'b1;
    logic [15:0]    d_in_data = 16'd3;
    logic           d_in_ready, d_out_valid, d_rate_busy;
    logic [19:0]    d_out_data;

    cic_decimator_mc #(.W(16), .OW(20), .CH(1), .N(3), .M(1), .RL_MAX(6)) dut20 (
        .clk(clk), .rst_n(rst_n), .rate_log2(d_rate),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
        .rate_busy(d_rate_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    longint hist [CH][$];
    longint h [$];
    int     m_phase, m_rl, m_outcount, m_beats;
    bit     m_snap, m_outv, model_on;
    longint m_outd [CH];
    int     busy_seen;
    bit     lit_en;
    longint lit_val [CH];

    function automatic int sat_rate(input int r);
        if (r == 0) return 1;
        if (r > RL_MAX) return RL_MAX;
        return r;
    endfunction

    function automatic void build_h(input int rl);
        int box = (1 << rl) * M;
        longint t [$];
        h = {};
        h.push_back(1);
        for (int s = 0; s < N; s++) begin
            t = {};
            for (int i = 0; i < h.size() + box - 1; i++) begin
                longint acc = 0;
                for (int j = 0; j < box; j++)
                    if (i - j >= 0 && i - j < h.size()) acc += h[i-j];
                t.push_back(acc);
            end
            h = t;
        end
    endfunction

    function automatic void model_clear(input int rl);
        for (int c = 0; c < CH; c++) hist[c].delete();
        m_phase    = 0;
        m_outcount = 0;
        m_rl       = rl;
        build_h(rl);
    endfunction

    function automatic longint model_out(input int c);
        longint v = 0;
        int n = hist[c].size();
        int s = N * (m_rl + M - 1) - (OW - W);
        longint vmax = (longint'(1) <<< (OW - 1)) - 1;
        for (int j = 0; j < h.size() && j < n; j++) v += h[j] * hist[c][n-1-j];
        if (s > 0) v = (v + (longint'(1) <<< (s - 1))) >>> s;
        else       v = v <<< (-s);
        if (v > vmax)      v = vmax;
        if (v < -vmax - 1) v = -vmax - 1;
        return v;
    endfunction

    // Compare at the falling edge, advance the model at the rising edge.
    initial begin
        bit d_rst, d_flush, d_acc, d_load, d_ordy, e_flush, e_ir, bnd;
        int d_rate_v;
        longint d_in [CH];
        model_on = 0;
        busy_seen = 0;
        forever begin
            @(negedge clk);
            e_flush = (sat_rate(int'(rate_log2)) != m_rl) && !m_snap;
            e_ir    = !e_flush && !(m_snap && m_outv && !out_ready);
            if (model_on) begin
                check("in_ready", longint'(in_ready), longint'(e_ir));
                check("rate_busy", longint'(rate_busy), longint'(e_flush));
                check("out_valid", longint'(out_valid), longint'(m_outv));
                if (rate_busy) busy_seen++;
                if (m_outv)
                    for (int c = 0; c < CH; c++)
                        check($sformatf("out_data_ch%0d", c),
                              longint'($signed(out_data[c*OW +: OW])), m_outd[c]);
                if (lit_en && m_outv && m_outcount >= 3)
                    for (int c = 0; c < CH; c++)
                        check($sformatf("steady_ch%0d", c),
                              longint'($signed(out_data[c*OW +: OW])), lit_val[c]);
            end
            d_rst    = !rst_n;
            d_flush  = e_flush;
            d_acc    = in_valid && e_ir;
            d_load   = m_snap && (!m_outv || out_ready);
            d_ordy   = out_ready;
            d_rate_v = sat_rate(int'(rate_log2));
            for (int c = 0; c < CH; c++) d_in[c] = longint'($signed(in_data[c*W +: W]));
            @(posedge clk);
            if (d_rst) begin
                model_clear(d_rate_v);
                m_snap = 0;
                m_outv = 0;
                for (int c = 0; c < CH; c++) m_outd[c] = 0;
                model_on = 1;
            end else if (d_flush) begin
                model_clear(d_rate_v);
                if (d_ordy) m_outv = 0;
            end else begin
                if (d_load) begin
                    for (int c = 0; c < CH; c++) m_outd[c] = model_out(c);
                    m_outv = 1;
                    m_outcount++;
                end else if (d_ordy) begin
                    m_outv = 0;
                end
                bnd = 0;
                if (d_acc) begin
                    for (int c = 0; c < CH; c++) begin
                        hist[c].push_back(d_in[c]);
                        if (hist[c].size() > 256) void'(hist[c].pop_front());
                    end
                    bnd = (m_phase == (1 << m_rl) - 1);
                    m_phase = bnd ? 0 : m_phase + 1;
                    m_beats++;
                end
                m_snap = (m_snap && !d_load) || bnd;
            end
        end
    end

    // OW = 20 instance: constant 3 at R = 2 must settle to 3 * 2^4 = 48.
    initial begin
        int cnt = 0;
        @(posedge rst_n);
        repeat (60) begin
            @(negedge clk);
            if (d_out_valid) begin
                cnt++;
                if (cnt >= 3) check("ow20_steady", longint'($signed(d_out_data)), 48);
            end
        end
        check("ow20_output_count_ge10", longint'(cnt >= 10), 1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_data(input int a, input int b, input int c, input int d);
        in_data = {16'(d), 16'(c), 16'(b), 16'(a)};
    endtask

    initial begin
        int cyc, start_beats;
        rst_n = 1'b0; rate_log2 = 3'd2; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; lit_en = 1'b0; m_beats = 0;
        for (int c = 0; c < CH; c++) lit_val[c] = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_in_ready", longint'(in_ready), 1);
        check("reset_rate_busy", longint'(rate_busy), 0);
        check("reset_out_data_zero", longint'(out_data == '0), 1);

        // Constant channels at R = 4.
        step(1);
        set_data(1000, -1000, 0, 12345);
        lit_val[0] = 1000; lit_val[1] = -1000; lit_val[2] = 0; lit_val[3] = 12345;
        lit_en = 1'b1;
        in_valid = 1'b1;
        step(60);

        // Rate change 2 -> 5 mid-stream; exactly one flush cycle.
        busy_seen = 0;
        rate_log2 = 3'd5;
        step(300);
        check("rate_busy_cycles", busy_seen, 1);

        // Full-scale constants at R = 64.
        lit_en = 1'b0;
        rate_log2 = 3'd6;
        set_data(32767, -32768, 32767, -32768);
        step(3);
        lit_val[0] = 32767; lit_val[1] = -32768; lit_val[2] = 32767; lit_val[3] = -32768;
        lit_en = 1'b1;
        step(420);
        lit_en = 1'b0;

        // Hold the output, then reset mid-block.
        out_ready = 1'b0;
        step(80);
        check("held_out_valid", longint'(out_valid), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_out_valid", longint'(out_valid), 0);
        check("post_reset_in_ready", longint'(in_ready), 1);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("post_reset_first_output_cycles", cyc, 65);
        step(1);
        out_ready = 1'b1;

        // Randomised traffic with 30% out_ready and periodic rate changes.
        start_beats = m_beats;
        cyc = 0;
        while ((m_beats - start_beats) < 10000 && cyc < 60000) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(99) < 80);
            out_ready = ($urandom_range(99) < 30);
            in_data   = {$urandom(), $urandom()};
            if ((cyc % 1500) == 1499) rate_log2 = 3'($urandom_range(7));
            cyc++;
        end
        if (cyc >= 60000) check("random_beats_within_budget", m_beats - start_beats, 10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
